seq_match_logger: RTL

- Downstream consumer of the Mealy sequence detector's one-cycle `data_out` match pulse.
- Timestamps every detected match with a free-running cycle counter and buffers the stamps in a small FIFO.
- Presents stamps to a host/readout stage over a valid/ready handshake, so bursts of overlapping matches are not lost.
- Also keeps a saturating total-match count and a sticky overflow flag.

---
 rtl/seq_match_logger.sv | 110 +++++++++++
 1 files changed

// File: rtl/seq_match_logger.sv
// Timestamps match pulses into a first-word-fall-through FIFO with valid/ready readout.
// Define SEQ_MATCH_LOGGER_DELTA_EN to store saturating inter-match deltas instead of absolute stamps.
module seq_match_logger #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     match_in,
  output logic [TS_W-1:0]          ts_data,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         match_total
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  typedef logic [PtrW:0] count_t;

  logic [TS_W-1:0]  ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  count_t           count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [TS_W-1:0]  wr_val;
  logic             full, push_req, push, pop;

  always_comb begin
    full     = (count_q == count_t'(DEPTH));
    ts_valid = (count_q != '0);
    push_req = enable & match_in;
    pop      = ts_valid & ts_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = push_req & (~full | pop);

    ts_cnt_d = enable ? ts_cnt_q + TS_W'(1) : ts_cnt_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + count_t'(1);
    end else if (!push && pop) begin
      count_d = count_q - count_t'(1);
    end

    overflow_d = overflow_q | (push_req & ~push);
    total_d    = (push && (total_q != '1)) ? total_q + CNT_W'(1) : total_q;
  end

`ifdef SEQ_MATCH_LOGGER_DELTA_EN
  logic [TS_W-1:0] delta_q, delta_d;

  // The accepting edge is itself enabled, so the next delta starts at one.
  always_comb begin
    wr_val  = delta_q;
    delta_d = delta_q;
    if (push) begin
      delta_d = TS_W'(1);
    end else if (enable && (delta_q != '1)) begin
      delta_d = delta_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      delta_q <= '0;
    end else begin
      delta_q <= delta_d;
    end
  end
`else
  assign wr_val = ts_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wr_val;
    end
  end

  assign ts_data     = ts_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign match_total = total_q;

endmodule
